logic_unit_result_fifo: RTL and testbench
=========================================

// Module: logic_unit_result_fifo
// PURPOSE
//  Parametrised successor to the logic-unit output selector.
//  - Selects one of eight function results by fxn code, together with its V/C flags and a computed Z flag.
//  - Pushes the selected result into a DEPTH-entry FIFO with valid/ready handshakes on both sides.
//  - Sits between the logic-unit datapath (adders, complement, XNOR) and the display/consumer stage.
// PARAMETERS
//  WIDTH  6  data width of every operand/result bus (>=2)
//  DEPTH  4  FIFO entries; power of two, >=2
// PORTS
//  clk        in   1        single clock, rising edge
//  rst_n      in   1        asynchronous active-low reset
//  in_valid   in   1        selection request present this cycle
//  in_ready   out  1        FIFO can accept; = !full
//  fxn        in   3        function code, sampled on accept
//  a_o,b_o    in   WIDTH    pass-through A / B results
//  a_comp     in   WIDTH    complement of A
//  b_comp     in   WIDTH    complement of B
//  xnor_r     in   WIDTH    XNOR result
//  sum,sum2   in   WIDTH    adder / subtractor results
//  l          in   1        logic bit for fxn 100
//  c,v        in   1        carry/overflow belonging to sum
//  c2,v2      in   1        carry/overflow belonging to sum2
//  out_valid  out  1        head entry valid (= !empty)
//  out_ready  in   1        consumer takes head entry
//  o          out  WIDTH    head result
//  vo,co,zo   out  1        head overflow, carry, zero flags
//  count      out  $clog2(DEPTH)+1  current occupancy
//  flag_clr   in   1        clear sticky flags (feature only)
//  sticky_v   out  1        OR of popped V since last clear
//  sticky_c   out  1        OR of popped C since last clear
// BEHAVIOUR
//  Selection (combinational, captured on push):
//  - 000 -> a_o; 001 -> b_o; 010 -> a_comp; 011 -> b_comp.
//  - 100 -> {WIDTH-1 zeros, l}; 101 -> xnor_r.
//  - 110 -> sum with V=v, C=c; 111 -> sum2 with V=v2, C=c2.
//  - Codes 000-101 force V=C=0. No latched/held flags from earlier ops.
//  - Z = (selected result == 0), computed before storage.
//  Handshake / FIFO:
//  - Push when in_valid && in_ready; pop when out_valid && out_ready.
//  - Entry = {result, V, C, Z}; first-in first-out. Pointers wrap modulo DEPTH.
//  - Latency: pushed data appears on o the cycle after push when FIFO was empty. No combinational in->out path.
//  - Full: in_ready=0; in_valid ignored. No push-through-on-pop; in_ready is purely !full.
//  - Empty: out_valid=0; o/vo/co/zo hold the last read-slot contents (don't-care).
//  - Simultaneous push+pop when non-empty and not full: count unchanged, both happen.
//  - Simultaneous push+pop when empty: pop is ignored (out_valid=0); push occurs.
//  - Inputs other than in_valid/fxn/data are ignored when no push occurs.
//  Reset (async assert, sync deassert expected upstream):
//  - Pointers, count and sticky flags = 0. out_valid=0; in_ready=1 from the first cycle after reset.
//  - o, vo, co, zo = 0 (storage cleared).
//  - Reset mid-operation discards all entries immediately.
// CONFIGURATION
//  LU_STICKY_FLAGS_EN defined:
//  - sticky_v/sticky_c set on any pop whose entry has V/C = 1.
//  - flag_clr clears both next edge; set on the same cycle as flag_clr wins (event not lost).
//  Not defined: sticky_v = sticky_c = 0 constant; flag_clr unused.
// TESTING
//  - Reset, push fxn=110 sum=6'h3F c=1 v=0 -> next cycle out_valid=1, o=3F, co=1, vo=0, zo=0.
//  - Push 000..111 back-to-back with out_ready=0, DEPTH=4 -> in_ready=0 after 4 pushes, count=4.
//    Then drain: o order A, B, AComp, BComp.
//  - fxn=100 l=1 -> o=6'h01, zo=0; fxn=101 xnor_r=0 -> o=0, zo=1, vo=co=0.
//  - Full FIFO, in_valid=1 and out_ready=1 same cycle -> only pop; count 4->3; new data not stored.
//  - Push 6 entries while popping each the next cycle -> pointers wrap; order preserved, count never >2.
//  - rst_n low mid-stream with 3 entries -> out_valid=0, count=0, o=0 immediately.
//  - Macro on: pop entry with v2=1, flag_clr on same cycle -> sticky_v=1; then clr alone -> sticky_v=0.
//  - Macro off: sticky_v stays 0 for the same stimulus.

Source files
------------

// File: rtl/logic_unit_result_fifo.sv
// logic_unit_result_fifo
//   Selects one of eight logic-unit results by function code, attaches the
//   V/C flags and a computed Z flag, and queues the entry in a DEPTH-entry
//   FIFO with valid/ready handshakes on both sides.
//   Optional feature macro: LU_STICKY_FLAGS_EN (sticky V/C accumulated on pop).
module logic_unit_result_fifo #(
  parameter int WIDTH = 6,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [2:0]                   fxn,
  input  logic [WIDTH-1:0]             a_o,
  input  logic [WIDTH-1:0]             b_o,
  input  logic [WIDTH-1:0]             a_comp,
  input  logic [WIDTH-1:0]             b_comp,
  input  logic [WIDTH-1:0]             xnor_r,
  input  logic [WIDTH-1:0]             sum,
  input  logic [WIDTH-1:0]             sum2,
  input  logic                         l,
  input  logic                         c,
  input  logic                         v,
  input  logic                         c2,
  input  logic                         v2,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             o,
  output logic                         vo,
  output logic                         co,
  output logic                         zo,
  output logic [$clog2(DEPTH):0]       count,
  input  logic                         flag_clr,
  output logic                         sticky_v,
  output logic                         sticky_c
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             v;
    logic             c;
    logic             z;
  } entry_t;

  entry_t          r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  entry_t          w_sel;
  entry_t          w_head;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  // A pop on an empty FIFO is ignored; a push on a full FIFO is ignored.
  assign w_push  = in_valid && !w_full;
  assign w_pop   = out_ready && !w_empty;

  // Result/flag selection; only the adder codes carry V/C, Z is derived here.
  always_comb begin
    // NOTE: every field gets a default first so no path through the case
    // leaves a bit unassigned, which would otherwise infer a latch.
    w_sel = '0;
    unique case (fxn)
      3'b000: w_sel.res = a_o;
      3'b001: w_sel.res = b_o;
      3'b010: w_sel.res = a_comp;
      3'b011: w_sel.res = b_comp;
      3'b100: w_sel.res = {{(WIDTH-1){1'b0}}, l};
      3'b101: w_sel.res = xnor_r;
      3'b110: begin
        w_sel.res = sum;
        w_sel.v   = v;
        w_sel.c   = c;
      end
      3'b111: begin
        w_sel.res = sum2;
        w_sel.v   = v2;
        w_sel.c   = c2;
      end
      default: w_sel = '0;
    endcase
    w_sel.z = (w_sel.res == '0);
  end

  // Entry storage, written at the write pointer on every accepted push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the storage is cleared on reset because the head slot drives
      // o/vo/co/zo directly and those must read as zero out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples pre-edge values.
      r_mem[r_wr_ptr] <= w_sel;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_head    = r_mem[r_rd_ptr];
  assign o         = w_head.res;
  assign vo        = w_head.v;
  assign co        = w_head.c;
  assign zo        = w_head.z;
  assign out_valid = !w_empty;
  assign in_ready  = !w_full;
  assign count     = r_count;

`ifdef LU_STICKY_FLAGS_EN
  logic r_sticky_v;
  logic r_sticky_c;

  // Sticky flags: a popped V/C sets the flag; clear loses to a same-cycle set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky_v <= 1'b0;
      r_sticky_c <= 1'b0;
    end else begin
      if (w_pop && w_head.v) r_sticky_v <= 1'b1;
      else if (flag_clr)     r_sticky_v <= 1'b0;
      if (w_pop && w_head.c) r_sticky_c <= 1'b1;
      else if (flag_clr)     r_sticky_c <= 1'b0;
    end
  end

  assign sticky_v = r_sticky_v;
  assign sticky_c = r_sticky_c;
`else
  logic w_unused_flag_clr;

  assign w_unused_flag_clr = flag_clr;
  assign sticky_v          = 1'b0;
  assign sticky_c          = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_result_fifo.sv
// Testbench for logic_unit_result_fifo: directed scenarios plus random traffic
// compared every cycle against a queue-based model of the selector and FIFO.
module tb_logic_unit_result_fifo;

  localparam int WIDTH = 6;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2:0]       fxn;
  logic [WIDTH-1:0] a_o, b_o, a_comp, b_comp, xnor_r, sum, sum2, o;
  logic             l, c, v, c2, v2, vo, co, zo;
  logic [CW-1:0]    count;
  logic             flag_clr, sticky_v, sticky_c;

  always #5 clk = ~clk;

  logic_unit_result_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .fxn(fxn),
    .a_o(a_o), .b_o(b_o), .a_comp(a_comp), .b_comp(b_comp),
    .xnor_r(xnor_r), .sum(sum), .sum2(sum2),
    .l(l), .c(c), .v(v), .c2(c2), .v2(v2),
    .out_valid(out_valid), .out_ready(out_ready),
    .o(o), .vo(vo), .co(co), .zo(zo), .count(count),
    .flag_clr(flag_clr), .sticky_v(sticky_v), .sticky_c(sticky_c)
  );

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             v;
    logic             c;
    logic             z;
  } ent_t;

  ent_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   model_on = 0;
  bit   exp_zero_out = 1;
  bit   m_sv = 0;
  bit   m_sc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // What the selector should produce for the inputs currently applied.
  function automatic ent_t model_sel();
    ent_t e;
    e.v = 1'b0;
    e.c = 1'b0;
    case (fxn)
      3'd0: e.res = a_o;
      3'd1: e.res = b_o;
      3'd2: e.res = a_comp;
      3'd3: e.res = b_comp;
      3'd4: e.res = WIDTH'(l);
      3'd5: e.res = xnor_r;
      3'd6: begin e.res = sum;  e.v = v;  e.c = c;  end
      default: begin e.res = sum2; e.v = v2; e.c = c2; end
    endcase
    e.z = (e.res == 0);
    return e;
  endfunction

  task automatic rand_data();
    a_o    = WIDTH'($urandom);
    b_o    = WIDTH'($urandom);
    a_comp = WIDTH'($urandom);
    b_comp = WIDTH'($urandom);
    xnor_r = WIDTH'($urandom);
    sum    = WIDTH'($urandom);
    sum2   = WIDTH'($urandom);
    l      = 1'($urandom);
    c      = 1'($urandom);
    v      = 1'($urandom);
    c2     = 1'($urandom);
    v2     = 1'($urandom);
    fxn    = 3'($urandom);
  endtask

  task automatic set_idle();
    rand_data();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flag_clr  = 1'b0;
  endtask

  // One clock: the model applies the handshake rules at the rising edge,
  // then control returns at the following falling edge.
  task automatic tick();
    bit   push, pop;
    ent_t e;
    @(posedge clk);
    if (rst_n) begin
      push = in_valid && (q.size() < DEPTH);
      pop  = out_ready && (q.size() > 0);
      e    = model_sel();
      if (pop && q[0].v) m_sv = 1'b1;
      else if (flag_clr) m_sv = 1'b0;
      if (pop && q[0].c) m_sc = 1'b1;
      else if (flag_clr) m_sc = 1'b0;
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(e);
        exp_zero_out = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    logic exp_sv, exp_sc;
    if (model_on && rst_n) begin
      check("out_valid", out_valid, q.size() != 0);
      check("in_ready", in_ready, q.size() < DEPTH);
      check("count", count, q.size());
      if (q.size() != 0) begin
        check("o", o, q[0].res);
        check("vo", vo, q[0].v);
        check("co", co, q[0].c);
        check("zo", zo, q[0].z);
      end else if (exp_zero_out) begin
        check("o_reset", o, 0);
        check("flags_reset", {vo, co, zo}, 0);
      end
`ifdef LU_STICKY_FLAGS_EN
      exp_sv = m_sv;
      exp_sc = m_sc;
`else
      exp_sv = 1'b0;
      exp_sc = 1'b0;
`endif
      check("sticky_v", sticky_v, exp_sv);
      check("sticky_c", sticky_c, exp_sc);
    end
  end

  logic [WIDTH-1:0] exp_order [4];
  logic             exp_stk;

  initial begin
    set_idle();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_o", o, 0);
    rst_n = 1'b1;
    q.delete();
    exp_zero_out = 1'b1;
    model_on = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1);

    // Single push of the adder result.
    rand_data();
    in_valid = 1'b1; fxn = 3'b110; sum = 6'h3F; c = 1'b1; v = 1'b0;
    tick();
    check("t1_out_valid", out_valid, 1);
    check("t1_o", o, 6'h3F);
    check("t1_co", co, 1);
    check("t1_vo", vo, 0);
    check("t1_zo", zo, 0);
    set_idle();
    out_ready = 1'b1;
    tick();
    check("t1_drained", count, 0);

    // Back-to-back pushes of every code with the consumer stalled.
    set_idle();
    a_o = 6'h11; b_o = 6'h22; a_comp = 6'h2E; b_comp = 6'h1D;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      fxn = 3'(i);
      tick();
      if (i == 3) begin
        check("t2_full_ready", in_ready, 0);
        check("t2_full_count", count, 4);
      end
    end
    check("t2_still_full", count, 4);
    exp_order = '{6'h11, 6'h22, 6'h2E, 6'h1D};
    set_idle();
    for (int k = 0; k < 4; k++) begin
      check("t2_order", o, exp_order[k]);
      out_ready = 1'b1;
      tick();
    end
    check("t2_empty", out_valid, 0);

    // Logic bit and all-zero XNOR result.
    set_idle();
    in_valid = 1'b1; fxn = 3'b100; l = 1'b1;
    tick();
    check("t3_l_o", o, 6'h01);
    check("t3_l_zo", zo, 0);
    set_idle();
    in_valid = 1'b1; out_ready = 1'b1; fxn = 3'b101; xnor_r = '0;
    tick();
    check("t3_x_o", o, 0);
    check("t3_x_zo", zo, 1);
    check("t3_x_vc", {vo, co}, 0);
    set_idle();
    out_ready = 1'b1;
    tick();

    // Full FIFO with push and pop requested together: only the pop happens.
    for (int i = 0; i < 4; i++) begin
      rand_data();
      in_valid = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
      tick();
    end
    rand_data();
    in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("t4_count", count, 3);
    set_idle();
    out_ready = 1'b1;
    repeat (3) tick();

    // Streaming push/pop wraps the pointers without building occupancy.
    for (int i = 0; i < 6; i++) begin
      rand_data();
      in_valid = 1'b1; out_ready = 1'b1; flag_clr = 1'b0;
      tick();
      check("t5_count_le2", count <= 2, 1);
    end
    set_idle();
    out_ready = 1'b1;
    tick();

    // Sticky V: a set on the same cycle as clear wins; clear alone clears.
    set_idle();
    flag_clr = 1'b1;
    tick();
    set_idle();
    in_valid = 1'b1; fxn = 3'b111; v2 = 1'b1;
    tick();
    set_idle();
    out_ready = 1'b1; flag_clr = 1'b1;
    tick();
`ifdef LU_STICKY_FLAGS_EN
    exp_stk = 1'b1;
`else
    exp_stk = 1'b0;
`endif
    check("t6_sticky_set", sticky_v, exp_stk);
    set_idle();
    flag_clr = 1'b1;
    tick();
    check("t6_sticky_clr", sticky_v, 0);

    // Random traffic with phases biased toward filling and draining.
    for (int i = 0; i < 3000; i++) begin
      rand_data();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) == 0)
                                        : ($urandom_range(0, 3) != 0);
      flag_clr  = ($urandom_range(0, 7) == 0);
      tick();
    end

    // Asynchronous reset with three entries queued.
    set_idle();
    out_ready = 1'b1;
    repeat (DEPTH) tick();
    for (int i = 0; i < 3; i++) begin
      rand_data();
      in_valid = 1'b1; out_ready = 1'b0; flag_clr = 1'b0;
      fxn = 3'b000; a_o = 6'h2A;
      tick();
    end
    check("t7_pre_count", count, 3);
    set_idle();
    #2 rst_n = 1'b0;
    #1;
    check("t7_out_valid", out_valid, 0);
    check("t7_count", count, 0);
    check("t7_o", o, 0);
    check("t7_in_ready", in_ready, 1);
    q.delete();
    m_sv = 1'b0;
    m_sc = 1'b0;
    exp_zero_out = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
